// File: rtl/serial_pkg.sv
// Shared definitions for the serial byte transmitter and its matching receiver.
package serial_pkg;

    // Frame geometry: one start bit, eight data bits, one stop bit.
    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = DATA_BITS + 2;

    // Line protocol phases, common to transmit and receive sides.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } serial_state_t;

    // Total clock cycles one frame occupies on the line for a given bit time.
    function automatic int frame_cycles(input int clks_per_bit);
        return FRAME_BITS * clks_per_bit;
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period timer: pulses tick for one cycle at the end of every bit period.
module baud_tick_gen #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam logic [15:0] LAST_COUNT = 16'(CLKS_PER_BIT - 1);

    logic [15:0] count;

    assign tick = enable && (count == LAST_COUNT);

    // Count 0..CLKS_PER_BIT-1 while enabled; drop back to zero whenever idle.
    always_ff @(posedge clock) begin
        if (reset || !enable) begin
            count <= '0;
        end else if (count == LAST_COUNT) begin
            count <= '0;
        end else begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/serial_byte_tx.sv
// UART-style byte transmitter: start bit, 8 data bits LSB first, stop bit.
module serial_byte_tx
    import serial_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       send,
    output logic       ready,
    output logic       tx,
    output logic       busy
);

    serial_state_t          state;
    serial_state_t          next_state;
    logic [DATA_BITS-1:0]   shift_reg;
    logic [DATA_BITS-1:0]   next_shift;
    logic [2:0]             bit_cnt;
    logic [2:0]             next_bit_cnt;
    logic                   tx_reg;
    logic                   next_tx;
    logic                   ready_int;
    logic                   bit_tick;

    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick_gen (
        .clock (clock),
        .reset (reset),
        .enable(state != IDLE),
        .tick  (bit_tick)
    );

    // Ready also covers the final stop-bit cycle so a held send chains frames with no gap.
    always_comb begin
        next_state   = state;
        next_shift   = shift_reg;
        next_bit_cnt = bit_cnt;
        next_tx      = tx_reg;
        ready_int    = 1'b0;

        unique case (state)
            IDLE: begin
                ready_int = 1'b1;
                next_tx   = 1'b1;
            end
            START: begin
                if (bit_tick) begin
                    next_state   = DATA;
                    next_bit_cnt = 3'd0;
                    next_tx      = shift_reg[0];
                end
            end
            DATA: begin
                if (bit_tick) begin
                    if (bit_cnt == 3'(DATA_BITS - 1)) begin
                        next_state = STOP;
                        next_tx    = 1'b1;
                    end else begin
                        next_bit_cnt = bit_cnt + 3'd1;
                        next_shift   = shift_reg >> 1;
                        next_tx      = shift_reg[1];
                    end
                end
            end
            STOP: begin
                if (bit_tick) begin
                    ready_int  = 1'b1;
                    next_state = IDLE;
                    next_tx    = 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
                next_tx    = 1'b1;
            end
        endcase

        if (send && ready_int) begin
            next_state   = START;
            next_shift   = data_in;
            next_bit_cnt = 3'd0;
            next_tx      = 1'b0;
        end
    end

    // State and datapath registers; reset wins over any send on the same edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            tx_reg    <= 1'b1;
        end else begin
            state     <= next_state;
            shift_reg <= next_shift;
            bit_cnt   <= next_bit_cnt;
            tx_reg    <= next_tx;
        end
    end

    assign ready = ready_int;
    assign busy  = ~ready_int;
    assign tx    = tx_reg;

endmodule

// File: tb/tb_serial_byte_tx.sv
// Directed, table-driven bench for serial_byte_tx with a 4-cycle bit time.
module tb_serial_byte_tx;

    localparam int CLKS = 4;
    localparam int FRAME = CLKS * 10;

    logic       clock = 1'b0;
    logic       reset;
    logic       send;
    logic [7:0] data_in;
    logic       ready;
    logic       tx;
    logic       busy;

    int assertCount = 0;
    int failCount   = 0;

    typedef struct {
        logic       reset;
        logic       send;
        logic [7:0] data_in;
        logic       exp_tx;
        logic       exp_ready;
    } vec_t;

    vec_t vec_q[$];

    serial_byte_tx #(
        .CLKS_PER_BIT(CLKS)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .data_in(data_in),
        .send   (send),
        .ready  (ready),
        .tx     (tx),
        .busy   (busy)
    );

    // Free-running 10-time-unit clock.
    always #5 clock = ~clock;

    // Expected line level j cycles after the accepting edge of a frame carrying d.
    function automatic logic frameBit(input logic [7:0] d, input int j);
        int k;
        k = j / CLKS;
        if (k == 0) return 1'b0;
        else if (k <= 8) return d[k-1];
        else return 1'b1;
    endfunction

    task automatic applyStimulus(input logic r, input logic s, input logic [7:0] d);
        reset   = r;
        send    = s;
        data_in = d;
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic checkOutput(input string tag, input logic exp_tx, input logic exp_ready);
        assertCount++;
        if (tx !== exp_tx) begin
            failCount++;
            $display("[TB] FAIL %s tx: got %b expected %b", tag, tx, exp_tx);
        end
        assertCount++;
        if (ready !== exp_ready) begin
            failCount++;
            $display("[TB] FAIL %s ready: got %b expected %b", tag, ready, exp_ready);
        end
        assertCount++;
        if (busy !== ~exp_ready) begin
            failCount++;
            $display("[TB] FAIL %s busy: got %b expected %b", tag, busy, ~exp_ready);
        end
    endtask

    task automatic addVec(input logic r, input logic s, input logic [7:0] d,
                          input logic etx, input logic erdy);
        vec_t v;
        v.reset     = r;
        v.send      = s;
        v.data_in   = d;
        v.exp_tx    = etx;
        v.exp_ready = erdy;
        vec_q.push_back(v);
    endtask

    // Accept a byte on the next edge, then scramble data_in; ends at frame cycle 0.
    task automatic sendByte(input logic [7:0] d);
        applyStimulus(1'b0, 1'b1, d);
        tick();
        applyStimulus(1'b0, 1'b0, ~d);
    endtask

    // Check frame cycles first..last, ticking between them; ends on cycle last.
    task automatic checkFrame(input string tag, input logic [7:0] d, input int first, input int last);
        for (int j = first; j <= last; j++) begin
            checkOutput($sformatf("%s j=%0d", tag, j), frameBit(d, j), j == FRAME - 1);
            if (j != last) tick();
        end
    endtask

    // Stimulus: vector table, then multi-cycle corner-case sequences.
    initial begin
        applyStimulus(1'b1, 1'b0, 8'h00);

        addVec(1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) addVec(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        addVec(1'b0, 1'b1, 8'hA5, frameBit(8'hA5, 0), 1'b0);
        for (int j = 1; j < FRAME; j++) addVec(1'b0, 1'b0, 8'h5A, frameBit(8'hA5, j), j == FRAME - 1);
        addVec(1'b0, 1'b0, 8'h5A, 1'b1, 1'b1);

        for (int i = 0; i < vec_q.size(); i++) begin
            applyStimulus(vec_q[i].reset, vec_q[i].send, vec_q[i].data_in);
            tick();
            checkOutput($sformatf("vec[%0d]", i), vec_q[i].exp_tx, vec_q[i].exp_ready);
        end

        $display("[TB] back-to-back frames 00 then FF");
        applyStimulus(1'b0, 1'b1, 8'h00);
        tick();
        for (int j = 0; j < 2 * FRAME; j++) begin
            checkOutput($sformatf("b2b j=%0d", j),
                        frameBit((j < FRAME) ? 8'h00 : 8'hFF, j % FRAME),
                        (j % FRAME) == FRAME - 1);
            if (j == 0) applyStimulus(1'b0, 1'b1, 8'hFF);
            if (j == FRAME) applyStimulus(1'b0, 1'b0, 8'h00);
            tick();
        end
        checkOutput("b2b idle", 1'b1, 1'b1);

        $display("[TB] send during frame is ignored");
        sendByte(8'h3C);
        checkFrame("busy_send", 8'h3C, 0, 9);
        applyStimulus(1'b0, 1'b1, 8'h00);
        tick();
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkFrame("busy_send", 8'h3C, 10, FRAME - 1);
        tick();
        checkOutput("busy_send idle", 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            tick();
            checkOutput($sformatf("busy_send noqueue %0d", i), 1'b1, 1'b1);
        end

        $display("[TB] reset mid-frame");
        sendByte(8'h55);
        checkFrame("abort", 8'h55, 0, 16);
        applyStimulus(1'b1, 1'b0, 8'h55);
        tick();
        checkOutput("abort reset", 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 8'h55);
        tick();
        checkOutput("abort after", 1'b1, 1'b1);
        sendByte(8'h81);
        checkFrame("post_abort", 8'h81, 0, FRAME - 1);
        tick();
        checkOutput("post_abort idle", 1'b1, 1'b1);

        $display("[TB] reset and send together");
        applyStimulus(1'b1, 1'b1, 8'hF0);
        tick();
        checkOutput("rst_send", 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 8'hF0);
        for (int i = 0; i < 6; i++) begin
            tick();
            checkOutput($sformatf("rst_send idle %0d", i), 1'b1, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/serial_byte_tx.md
SERIAL_BYTE_TX -- requirements
Module: serial_byte_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clock cycles per serial bit (115200 baud at 100 MHz); legal range 2..65535.
REQ-002 clock  input  1  single system clock; all logic SHALL be on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising edge of clock.
REQ-004 data_in  input  8  byte to transmit, sampled only on an accepted send.
REQ-005 send  input  1  request to transmit data_in, level-sampled.
REQ-006 ready  output  1  high when idle and able to accept send.
REQ-007 tx  output  1  serial line, idle high, driven from a flip-flop (no combinational path to output).
REQ-008 busy  output  1  high while a frame is in progress; SHALL equal ~ready at all times.

Function
REQ-009 Frame format SHALL be 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); each bit held exactly CLKS_PER_BIT cycles; frame = 10*CLKS_PER_BIT cycles.
REQ-010 States SHALL be IDLE, START, DATA, STOP; IDLE->START on accepted send; START->DATA after CLKS_PER_BIT cycles; DATA->STOP after 8th bit period; STOP->IDLE after CLKS_PER_BIT cycles.
REQ-011 A send is accepted on a rising edge where send=1 and ready=1; data_in SHALL be latched into an internal shift register on that same edge.
REQ-012 tx SHALL go low on the first edge after acceptance (latency 1 cycle), and ready SHALL be low from that same cycle.
REQ-013 send asserted while ready=0 SHALL be ignored, neither queued nor altering the frame in flight.
REQ-014 Changes to data_in after acceptance SHALL NOT affect the frame in flight.
REQ-015 Bit counter 3 bits, 0..7; baud counter 16 bits, counts 0..CLKS_PER_BIT-1, then wraps to 0 and advances the bit; no other wrap points.
REQ-016 ready SHALL return high on the cycle the STOP bit period ends; send held continuously high SHALL start the next frame in that cycle, giving back-to-back frames with no idle gap between stop and next start.
REQ-017 In IDLE, tx SHALL be 1.

Reset
REQ-018 On reset: state=IDLE, tx=1, ready=1, busy=0, counters=0, shift register=0, all valid on the edge after reset is sampled high.
REQ-019 Reset asserted mid-frame SHALL abort the frame immediately; tx high on the next edge; no partial bits resume afterwards.
REQ-020 Reset SHALL take priority over a simultaneous send; that send is dropped.

Structure
REQ-021 Shared package serial_pkg SHALL hold the state encoding (IDLE, START, DATA, STOP), DATA_BITS=8 and FRAME_BITS=10, for reuse by the matching receiver.
REQ-022 One sub-module, baud_tick_gen (parameter CLKS_PER_BIT; ports clock, reset, enable, tick), SHALL produce the one-cycle bit-boundary tick; it clears its count when enable=0.

Verification (benches use CLKS_PER_BIT=4)
REQ-023 Reset, then idle 20 cycles -> tx=1, ready=1, busy=0 throughout.
REQ-024 send=1 for 1 cycle with data_in=8'hA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1 each 4 cycles, 40 cycles total; ready high again at cycle 41.
REQ-025 send held high with data_in=8'h00 then 8'hFF -> two contiguous 40-cycle frames, no idle cycle between them.
REQ-026 send pulsed at cycle 10 of a frame for 8'h3C with data_in changed to 8'h00 -> 8'h3C frame unaffected, second send ignored.
REQ-027 reset asserted at cycle 17 of an 8'h55 frame -> tx=1, ready=1 next edge; a new send of 8'h81 yields a clean full frame.
REQ-028 send and reset high on the same edge -> no frame starts; tx stays 1.
